// File: rtl/arith_pkg.sv
// Purpose : shared operation encoding and parameter helpers for the inc/negate datapath.
// Latency : n/a (types and constant functions only).
// Backpr. : n/a.
package arith_pkg;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_INC  = 2'b01,
    OP_NOT  = 2'b10,
    OP_NEG  = 2'b11
  } op_e;

  // Integer ceiling division, used to size the pipeline at elaboration time.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/pipelined_inc_negate_ha_segment.sv
// Purpose : W-bit half-adder carry chain (adds a single carry-in to a W-bit word).
// Latency : combinational.
// Backpr. : none; pure logic.
// Ports   : a_i word in, cin_i carry in, sum_o sum, cout_o carry out of bit W-1,
//           cmsb_o carry into bit W-1.
module ha_segment #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         cmsb_o
);

  logic [W:0] c;

  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int i = 0; i < W; i++) begin
      sum_o[i] = a_i[i] ^ c[i];
      c[i+1]   = a_i[i] & c[i];
    end
  end

  assign cout_o = c[W];
  assign cmsb_o = c[W-1];

endmodule

// File: rtl/pipelined_inc_negate.sv
// Purpose : pass / increment / ones' complement / negate of a WIDTH-bit operand,
//           carry chain split into SEG-bit segments, one pipeline stage each.
// Latency : NSTAGE = ceil(WIDTH/SEG) cycles; throughput 1/cycle.
// Backpr. : whole pipeline holds when out_valid && !out_ready; in_ready = advance.
// Ports   : clk, rst_n (async active-low); in_valid/in_ready/in_data/in_op operand side;
//           out_valid/out_ready/out_data/out_cout/out_ovf result side.
module pipelined_inc_negate
  import arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NSTAGE = ceil_div(WIDTH, SEG);
  // Width of the top segment; narrower than SEG when WIDTH is not a multiple.
  localparam int LASTW  = WIDTH - (NSTAGE - 1) * SEG;

  op_e op;
  logic adv;

  // Inter-stage buses: index 0 is the formatted input, index k+1 is stage k's register.
  logic             vld_s  [NSTAGE+1];
  logic [WIDTH-1:0] dat_s  [NSTAGE+1];
  logic             cy_s   [NSTAGE+1];
  logic             cmsb_s [NSTAGE+1];

  assign op       = op_e'(in_op);
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign vld_s[0]  = in_valid;
  assign dat_s[0]  = (op == OP_NOT || op == OP_NEG) ? ~in_data : in_data;
  assign cy_s[0]   = (op == OP_INC || op == OP_NEG);
  assign cmsb_s[0] = 1'b0;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int W = (k == NSTAGE - 1) ? LASTW : SEG;

    logic [W-1:0]     seg_sum;
    logic             seg_cout;
    logic             seg_cmsb;
    logic [WIDTH-1:0] dat_d;
    logic             cmsb_d;
    logic             vld_q;
    logic [WIDTH-1:0] dat_q;
    logic             cy_q;
    logic             cmsb_q;

    ha_segment #(.W(W)) u_seg (
      .a_i    (dat_s[k][k*SEG +: W]),
      .cin_i  (cy_s[k]),
      .sum_o  (seg_sum),
      .cout_o (seg_cout),
      .cmsb_o (seg_cmsb)
    );

    // Resolve this stage's segment; higher segments pass through still raw.
    always_comb begin
      dat_d               = dat_s[k];
      dat_d[k*SEG +: W]   = seg_sum;
    end

    // The MSB lives in the last segment, so its carry-in is only known there.
    assign cmsb_d = (k == NSTAGE - 1) ? seg_cmsb : cmsb_s[k];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        dat_q  <= '0;
        cy_q   <= 1'b0;
        cmsb_q <= 1'b0;
      end else if (adv) begin
        vld_q  <= vld_s[k];
        dat_q  <= dat_d;
        cy_q   <= seg_cout;
        cmsb_q <= cmsb_d;
      end
    end

    assign vld_s[k+1]  = vld_q;
    assign dat_s[k+1]  = dat_q;
    assign cy_s[k+1]   = cy_q;
    assign cmsb_s[k+1] = cmsb_q;
  end

  assign out_valid = vld_s[NSTAGE];
  assign out_data  = dat_s[NSTAGE];
  assign out_cout  = cy_s[NSTAGE];
  // Signed overflow: carry into MSB differs from carry out of MSB.
  assign out_ovf   = cmsb_s[NSTAGE] ^ cy_s[NSTAGE];

endmodule
